audio_mem_ctrl: RTL

Memory-side controller for the record/playback path. It sits directly downstream of the key/record controller and answers its `write_req`/`read_req` handshakes. While `record` is high it stores ADC samples into a linear word memory. While `play` is high it streams the same number of samples back to the DAC, followed by silence.

---
 rtl/audio_pkg.sv | 15 +
 rtl/audio_sample_hold.sv | 49 ++++
 rtl/audio_mem_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the record/playback memory controller.
package audio_pkg;

  localparam int AUDIO_DATA_W = 32;
  localparam logic [AUDIO_DATA_W-1:0] AUDIO_SILENCE = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ACK,
    ST_RECORD,
    ST_RD_ACK,
    ST_PLAY
  } audio_state_e;

endpackage

// File: rtl/audio_sample_hold.sv
// One-entry valid/data holding register. A load while full and not being
// drained is refused and flagged on overrun_o; clear_i dominates.
module audio_sample_hold #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              accept_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              overrun_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else begin
      if (accept_i) valid_d = 1'b0;
      // A load in the same cycle as the drain takes the freed slot.
      if (load_i && (!valid_q || accept_i)) begin
        valid_d = 1'b1;
        data_d  = data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign overrun_o = load_i & valid_q & ~accept_i & ~clear_i;

endmodule

// File: rtl/audio_mem_ctrl.sv
// Memory-side record/playback controller: captures ADC samples into linear
// word memory and streams the recorded length back to the DAC.
module audio_mem_ctrl
  import audio_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = AUDIO_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_req,
  output logic              write_req_ack,
  input  logic              read_req,
  output logic              read_req_ack,
  input  logic              record,
  input  logic              play,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              dac_req,
  output logic [DATA_W-1:0] dac_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid,
  output logic [ADDR_W:0]   rec_len,
  output logic              full,
  output logic              overrun
);

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  audio_state_e      state_q, state_d;
  logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
  logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_W:0]   rec_len_q, rec_len_d;
  logic              full_q, full_d;
  logic              ovr_q, ovr_d;
  logic              rd_cmd_q, rd_cmd_d;
  logic              rd_out_q, rd_out_d;
  logic [DATA_W-1:0] dac_q, dac_d;

  logic              wh_load, wh_clear, wh_valid, wh_ovr;
  logic [DATA_W-1:0] wh_data;
  logic              pf_load, pf_accept, pf_clear, pf_valid, pf_ovr_unused;
  logic [DATA_W-1:0] pf_data;

  logic              wr_accept, rd_accept, drained, rd_done, leaving;
  logic [ADDR_W:0]   wr_fill;

  audio_sample_hold #(.DATA_W(DATA_W)) u_wr_hold (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clear_i   (wh_clear),
    .load_i    (wh_load),
    .accept_i  (wr_accept),
    .data_i    (adc_data),
    .valid_o   (wh_valid),
    .data_o    (wh_data),
    .overrun_o (wh_ovr)
  );

  audio_sample_hold #(.DATA_W(DATA_W)) u_rd_prefetch (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clear_i   (pf_clear),
    .load_i    (pf_load),
    .accept_i  (pf_accept),
    .data_i    (mem_rdata),
    .valid_o   (pf_valid),
    .data_o    (pf_data),
    .overrun_o (pf_ovr_unused)
  );

  assign wr_accept = wh_valid & mem_ready;
  assign rd_accept = rd_cmd_q & mem_ready;
  assign drained   = ~rd_cmd_q & ~rd_out_q;
  assign rd_done   = (rd_cnt_q == rec_len_q) & ~pf_valid & drained;
  assign leaving   = write_req | read_req | ~play;
  // Count the pending hold entry so a sample can never be placed past capacity.
  assign wr_fill   = wr_cnt_q + {{ADDR_W{1'b0}}, wh_valid};

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_accept ? sat_inc(wr_cnt_q) : wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    rec_len_d = rec_len_q;
    full_d    = full_q;
    ovr_d     = ovr_q | wh_ovr;
    rd_cmd_d  = rd_cmd_q & ~mem_ready;
    rd_out_d  = rd_out_q;
    dac_d     = dac_q;
    wh_load   = 1'b0;
    wh_clear  = 1'b0;
    pf_load   = 1'b0;
    pf_accept = 1'b0;
    pf_clear  = 1'b0;

    if (rd_accept) rd_out_d = 1'b1;
    if (rd_out_q && mem_rdata_valid) rd_out_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (write_req) begin
          state_d  = ST_WR_ACK;
          wr_cnt_d = '0;
          full_d   = 1'b0;
          ovr_d    = 1'b0;
          wh_clear = 1'b1;
        end else if (read_req) begin
          state_d  = ST_RD_ACK;
          rd_cnt_d = '0;
          pf_clear = 1'b1;
        end
      end
      ST_WR_ACK: state_d = ST_RECORD;
      ST_RECORD: begin
        if (write_req) begin
          state_d  = ST_WR_ACK;
          wr_cnt_d = '0;
          full_d   = 1'b0;
          ovr_d    = 1'b0;
          wh_clear = 1'b1;
        end else begin
          if (record && adc_valid) begin
            if (wr_fill >= CAP) full_d = 1'b1;
            else                wh_load = 1'b1;
          end
          // Leave only once the last held sample has been accepted.
          if (!record && (!wh_valid || wr_accept)) begin
            rec_len_d = wr_cnt_d;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_RD_ACK: begin
        state_d  = ST_PLAY;
        rd_cmd_d = (rec_len_q != '0);
      end
      ST_PLAY: begin
        if (leaving) begin
          // Outstanding read data is discarded; exit waits for the bus to go quiet.
          if (drained) begin
            dac_d    = DATA_W'(AUDIO_SILENCE);
            pf_clear = 1'b1;
            if (write_req) begin
              state_d  = ST_WR_ACK;
              wr_cnt_d = '0;
              full_d   = 1'b0;
              ovr_d    = 1'b0;
              wh_clear = 1'b1;
            end else if (read_req) begin
              state_d  = ST_RD_ACK;
              rd_cnt_d = '0;
            end else begin
              state_d  = ST_IDLE;
            end
          end
        end else begin
          if (rd_out_q && mem_rdata_valid) begin
            pf_load  = 1'b1;
            rd_cnt_d = sat_inc(rd_cnt_q);
          end
          if (dac_req) begin
            if (pf_valid) begin
              dac_d     = pf_data;
              pf_accept = 1'b1;
              if (rd_cnt_q < rec_len_q) rd_cmd_d = 1'b1;
            end else if (rd_done) begin
              dac_d = DATA_W'(AUDIO_SILENCE);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      rec_len_q <= '0;
      full_q    <= 1'b0;
      ovr_q     <= 1'b0;
      rd_cmd_q  <= 1'b0;
      rd_out_q  <= 1'b0;
      dac_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      rec_len_q <= rec_len_d;
      full_q    <= full_d;
      ovr_q     <= ovr_d;
      rd_cmd_q  <= rd_cmd_d;
      rd_out_q  <= rd_out_d;
      dac_q     <= dac_d;
    end
  end

  assign write_req_ack = (state_q == ST_WR_ACK);
  assign read_req_ack  = (state_q == ST_RD_ACK);
  assign mem_wr        = wh_valid;
  assign mem_wdata     = wh_data;
  assign mem_rd        = rd_cmd_q;
  assign mem_addr      = rd_cmd_q ? rd_cnt_q[ADDR_W-1:0] : wr_cnt_q[ADDR_W-1:0];
  assign dac_data      = dac_q;
  assign rec_len       = rec_len_q;
  assign full          = full_q;
  assign overrun       = ovr_q;

endmodule
